// File: rtl/timer_event_gen.sv
// timer_event_gen: event/compare stage downstream of the repeating up-counter.
// Produces registered wrap/compare pulses, per-channel PWM, sticky W1C status,
// a masked interrupt and a saturating count of wraps.
module timer_event_gen #(
    parameter int WIDTH   = 32,
    parameter int NUM_CMP = 2,
    parameter int PCNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [WIDTH-1:0]           cnt,
    input  logic [WIDTH-1:0]           cfg_max,
    input  logic [NUM_CMP*WIDTH-1:0]   cmp_val,
    input  logic [NUM_CMP:0]           irq_mask,
    input  logic [NUM_CMP:0]           clr,
    input  logic                       pcnt_clr,
    output logic                       wrap_pulse,
    output logic [NUM_CMP-1:0]         cmp_pulse,
    output logic [NUM_CMP-1:0]         pwm_out,
    output logic [NUM_CMP:0]           status,
    output logic                       irq,
    output logic [PCNT_W-1:0]          pcnt
);

    logic                 wrap_hit;
    logic [NUM_CMP-1:0]   cmp_hit;

    logic                 wrap_q,   wrap_d;
    logic [NUM_CMP-1:0]   cmp_q,    cmp_d;
    logic [NUM_CMP-1:0]   pwm_q,    pwm_d;
    logic [NUM_CMP:0]     status_q, status_d;
    logic [PCNT_W-1:0]    pcnt_q,   pcnt_d;

    // Event detection on the live count; the counter sits at its limit on the wrap cycle.
    always_comb begin
        wrap_hit = en && (cnt >= cfg_max);
        cmp_hit  = '0;
        pwm_d    = '0;
        for (int i = 0; i < NUM_CMP; i++) begin
            cmp_hit[i] = en && (cnt == cmp_val[i*WIDTH +: WIDTH]);
            pwm_d[i]   = en && (cnt <  cmp_val[i*WIDTH +: WIDTH]);
        end
    end

    // Next-state for pulses, sticky flags (set beats clear) and the saturating wrap count.
    always_comb begin
        wrap_d   = wrap_hit;
        cmp_d    = cmp_hit;
        status_d = {cmp_hit, wrap_hit} | (status_q & ~clr);
        pcnt_d   = pcnt_q;
        if (pcnt_clr) begin
            pcnt_d = wrap_hit ? PCNT_W'(1) : '0;
        end else if (wrap_hit && !(&pcnt_q)) begin
            pcnt_d = pcnt_q + PCNT_W'(1);
        end
    end

    // Output and state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q   <= 1'b0;
            cmp_q    <= '0;
            pwm_q    <= '0;
            status_q <= '0;
            pcnt_q   <= '0;
        end else begin
            wrap_q   <= wrap_d;
            cmp_q    <= cmp_d;
            pwm_q    <= pwm_d;
            status_q <= status_d;
            pcnt_q   <= pcnt_d;
        end
    end

    assign wrap_pulse = wrap_q;
    assign cmp_pulse  = cmp_q;
    assign pwm_out    = pwm_q;
    assign status     = status_q;
    assign pcnt       = pcnt_q;
    // Mask is applied combinationally so mask writes take effect immediately.
    assign irq        = |(status_q & irq_mask);

endmodule

// File: tb/tb_timer_event_gen.sv
// Directed bench for timer_event_gen with a counter model and an expected-result queue.
module tb_timer_event_gen;

    localparam int W  = 8;
    localparam int NC = 2;
    localparam int PW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [W-1:0]    cnt;
    logic [W-1:0]    cfg_max;
    logic [NC*W-1:0] cmp_val;
    logic [NC:0]     irq_mask;
    logic [NC:0]     clr;
    logic            pcnt_clr;
    logic            wrap_pulse;
    logic [NC-1:0]   cmp_pulse;
    logic [NC-1:0]   pwm_out;
    logic [NC:0]     status;
    logic            irq;
    logic [PW-1:0]   pcnt;

    timer_event_gen #(.WIDTH(W), .NUM_CMP(NC), .PCNT_W(PW)) dut (
        .clk(clk), .rst(rst), .en(en), .cnt(cnt), .cfg_max(cfg_max),
        .cmp_val(cmp_val), .irq_mask(irq_mask), .clr(clr), .pcnt_clr(pcnt_clr),
        .wrap_pulse(wrap_pulse), .cmp_pulse(cmp_pulse), .pwm_out(pwm_out),
        .status(status), .irq(irq), .pcnt(pcnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          wrap;
        logic [NC-1:0] cmp;
        logic [NC-1:0] pwm;
        logic [NC:0]   status;
        logic [PW-1:0] pcnt;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cnt_m    = 0;
    logic [NC:0]   m_status = '0;
    int            m_pcnt   = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wrap"},   8'(wrap_pulse), 8'h0);
        chk({tag, "_cmp"},    8'(cmp_pulse),  8'h0);
        chk({tag, "_pwm"},    8'(pwm_out),    8'h0);
        chk({tag, "_status"}, 8'(status),     8'h0);
        chk({tag, "_irq"},    8'(irq),        8'h0);
        chk({tag, "_pcnt"},   8'(pcnt),       8'h0);
    endtask

    // One clock: drive inputs, push the expected result, then compare after the edge.
    task automatic tick(input logic [NC:0] c, input logic pc);
        exp_t        e;
        exp_t        g;
        logic [W-1:0] cv;
        logic [NC:0] ev;
        @(negedge clk);
        clr      = c;
        pcnt_clr = pc;
        cnt      = W'(cnt_m);
        e.wrap   = en && (cnt_m >= int'(cfg_max));
        ev       = '0;
        ev[0]    = e.wrap;
        for (int ch = 0; ch < NC; ch++) begin
            cv         = cmp_val[ch*W +: W];
            e.cmp[ch]  = en && (cnt_m == int'(cv));
            e.pwm[ch]  = en && (cnt_m <  int'(cv));
            ev[ch+1]   = e.cmp[ch];
        end
        for (int k = 0; k <= NC; k++) begin
            if (c[k]) m_status[k] = 1'b0;
            if (ev[k]) m_status[k] = 1'b1;
        end
        if (pc)                       m_pcnt = e.wrap ? 1 : 0;
        else if (e.wrap && m_pcnt < 15) m_pcnt = m_pcnt + 1;
        e.status = m_status;
        e.pcnt   = PW'(m_pcnt);
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("wrap_pulse", 8'(wrap_pulse), 8'(g.wrap));
        chk("cmp_pulse",  8'(cmp_pulse),  8'(g.cmp));
        chk("pwm_out",    8'(pwm_out),    8'(g.pwm));
        chk("status",     8'(status),     8'(g.status));
        chk("pcnt",       8'(pcnt),       8'(g.pcnt));
        chk("irq",        8'(irq),        8'(|(g.status & irq_mask)));
        clr      = '0;
        pcnt_clr = 1'b0;
        if (en) cnt_m = (cnt_m >= int'(cfg_max)) ? 0 : cnt_m + 1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cnt = '0; cfg_max = '0; cmp_val = '0;
        irq_mask = '0; clr = '0; pcnt_clr = 1'b0;
        #3;
        chk_zero("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Normal counting: max 4, channel0 = 1, channel1 = 3, five full periods.
        cfg_max  = 8'd4;
        cmp_val  = {8'd3, 8'd1};
        irq_mask = 3'b111;
        en       = 1'b1;
        cnt_m    = 0;
        repeat (25) tick('0, 1'b0);
        chk("pcnt_after_5", 8'(pcnt), 8'd5);
        chk("status_all",   8'(status), 8'h7);

        // Asynchronous reset mid-cycle with flags set.
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        m_status = '0;
        m_pcnt   = 0;
        en       = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        cnt_m = 0;
        repeat (3) tick('0, 1'b0);
        chk_zero("post_rst_idle");

        // Set beats clear on a coincident wrap; clear alone then takes effect.
        en    = 1'b1;
        cnt_m = 0;
        repeat (9) tick('0, 1'b0);
        tick(3'b001, 1'b0);
        chk("set_wins", 8'(status[0]), 8'd1);
        tick(3'b001, 1'b0);
        chk("clr_only", 8'(status[0]), 8'd0);

        // Interrupt masking: wraps only with mask on compare0.
        cmp_val  = {8'd9, 8'd9};
        irq_mask = 3'b010;
        tick(3'b111, 1'b0);
        repeat (10) tick('0, 1'b0);
        chk("irq_masked", 8'(irq), 8'd0);
        irq_mask = 3'b011;
        #1 chk("irq_mask_comb_on", 8'(irq), 8'd1);
        irq_mask = 3'b010;
        #1 chk("irq_mask_comb_off", 8'(irq), 8'd0);
        cmp_val = {8'd9, 8'd1};
        repeat (5) tick('0, 1'b0);
        chk("irq_cmp0", 8'(irq), 8'd1);
        tick(3'b010, 1'b0);
        chk("irq_cleared", 8'(irq), 8'd0);

        // Boundary compare values.
        cmp_val = {8'd0, 8'd7};
        repeat (10) tick('0, 1'b0);
        chk("pwm_bounds", 8'(pwm_out), 8'h1);

        // Enable drop mid-period: pulses and PWM stop, status/pcnt hold.
        en = 1'b0;
        repeat (3) tick('0, 1'b0);
        en = 1'b1;

        // Wrap every cycle with max 0, saturation and clear-with-wrap.
        cfg_max = 8'd0;
        tick('0, 1'b1);
        repeat (20) tick('0, 1'b0);
        chk("pcnt_sat",   8'(pcnt), 8'd15);
        chk("wrap_every", 8'(wrap_pulse), 8'd1);
        tick('0, 1'b1);
        chk("pcnt_clr_wrap", 8'(pcnt), 8'd1);
        en = 1'b0;
        tick('0, 1'b1);
        chk("pcnt_clr_only", 8'(pcnt), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/timer_event_gen.md
Name: timer_event_gen

Overview:
- Event/compare stage that sits directly downstream of the repeating up-counter timer.
- Consumes the live count, the wrap limit and the enable, and produces:
  - registered wrap and compare-match pulses,
  - per-channel PWM outputs,
  - sticky status flags with write-1-to-clear,
  - a masked interrupt line,
  - a saturating period counter.

Parameters:
- WIDTH, 32, width of counter, limit and compare values
- NUM_CMP, 2, number of compare channels (1..8)
- PCNT_W, 16, width of saturating period counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  timer enable, same signal that drives the counter
- cnt  in  WIDTH  live count from the counter
- cfg_max  in  WIDTH  wrap limit; same value the counter uses
- cmp_val  in  NUM_CMP*WIDTH  compare values; channel i at [i*WIDTH +: WIDTH]
- irq_mask  in  NUM_CMP+1  interrupt enable per status bit
- clr  in  NUM_CMP+1  write-1-to-clear pulses per status bit
- pcnt_clr  in  1  synchronous clear of period counter
- wrap_pulse  out  1  one-cycle pulse per counter wrap
- cmp_pulse  out  NUM_CMP  one-cycle pulse per compare match
- pwm_out  out  NUM_CMP  PWM per channel
- status  out  NUM_CMP+1  sticky flags; bit0 = wrap, bit i+1 = compare i
- irq  out  1  OR of (status & irq_mask)
- pcnt  out  PCNT_W  number of wraps since clear, saturating

Behaviour:
- Reset: asserting rst clears all flops immediately, at any time including mid-period. All outputs read 0 during and after reset until the first qualifying event.
- Latency: all outputs are registered, one cycle after the sampled inputs. irq is combinational from status/irq_mask flops only.
- Wrap detect: wrap_hit = en && (cnt >= cfg_max), which is the cycle the counter sits at its limit.
  - wrap_pulse <= wrap_hit.
  - cfg_max = 0 with en = 1 gives wrap_pulse high every cycle.
  - Wrap is unsigned compare only; no other arithmetic.
- Compare i: hit_i = en && (cnt == cmp_val[i]); cmp_pulse[i] <= hit_i.
  - cmp_val[i] > cfg_max never matches.
  - cmp_val[i] = 0 matches on the first enabled cycle and after every wrap.
- PWM i: pwm_out[i] <= en && (cnt < cmp_val[i]).
  - cmp_val = 0 gives constant 0.
  - cmp_val > cfg_max gives constant 1 while en.
  - en = 0 forces 0 on the next edge.
- Status bit k:
  - Set on the same edge its pulse is registered.
  - Cleared by clr[k] = 1.
  - Set and clear in the same cycle: set wins and the bit stays 1.
  - clr on a bit already at 0 has no effect.
  - Flags hold while en = 0.
- irq: high whenever any status bit with its mask bit set is 1. Mask changes take effect combinationally, with no extra latency.
- Period counter pcnt:
  - Increments on wrap_hit and saturates at all-ones; never wraps.
  - pcnt_clr loads 0.
  - pcnt_clr together with wrap_hit in the same cycle loads 1.
  - Holds while en = 0.
- en deassert mid-period: pulses stop one cycle later, PWM drops, and status and pcnt hold their values.
- No handshake: inputs are sampled every cycle; clr and pcnt_clr are level-sampled, one action per high cycle.

Test Plan:
1. rst = 1 pulse mid-run with status = 3'b111, pcnt = 5 -> all outputs 0 immediately. After release with en = 0, outputs stay 0.
2. en = 1, cfg_max = 4, cmp_val = {3, 1}, counter model 0..4 repeating ->
   - wrap_pulse one cycle after each cnt = 4 (every 5 cycles),
   - cmp_pulse[0] after cnt = 1, cmp_pulse[1] after cnt = 3,
   - pwm_out[0] high 1 of 5 cycles, pwm_out[1] high 3 of 5,
   - pcnt increments once per period.
3. status[0] set, clr[0] = 1 issued in the same cycle as a new wrap_hit -> status[0] remains 1. clr[0] alone the next cycle -> 0.
4. irq_mask = 3'b010, only wrap events occur -> irq stays 0. A compare 0 match sets status[1] -> irq = 1. Clearing it -> irq = 0.
5. PCNT_W = 4, 20 wraps -> pcnt saturates at 15. pcnt_clr coincident with a wrap -> pcnt = 1.
6. cmp_val = {0, 7}, cfg_max = 4 -> pwm_out[0] constantly 1 and no cmp_pulse[0]; pwm_out[1] constantly 0. cfg_max = 0 -> wrap_pulse high every cycle.
